// File: rtl/elevator_call_panel.sv
// Hall call panel: debounces four call buttons, holds each press as a request
// until the car opens its door at that floor, with fire recall and overload masking.
module elevator_call_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic       door_open,
  input  logic [3:0] bcd_floor,
  input  logic       firealarm,
  input  logic       overload,
  output logic       reqG,
  output logic       reqF1,
  output logic       reqF2,
  output logic       reqF3,
  output logic [3:0] lamp,
  output logic       busy,
  output logic       err_floor
);

  localparam logic [1:0] REL   = 2'd0;
  localparam logic [1:0] DEB_P = 2'd1;
  localparam logic [1:0] PRS   = 2'd2;
  localparam logic [1:0] DEB_R = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_st  [4];
  logic [CNT_W-1:0] r_cnt [4];
  logic [3:0]       r_latch;
  logic             r_err;
  logic [3:0]       w_press;
  logic [3:0]       w_clr;
  logic [3:0]       w_req;

  always_comb begin
    w_press = '0;
    w_clr   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_press[i] = (r_st[i] == DEB_P) && btn_raw[i] && (r_cnt[i] == CNT_LAST);
      w_clr[i]   = door_open && (bcd_floor == 4'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_st[i]  <= REL;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        case (r_st[i])
          REL: begin
            if (btn_raw[i]) begin
              r_st[i]  <= DEB_P;
              r_cnt[i] <= CNT_ONE;
            end else begin
              r_cnt[i] <= '0;
            end
          end
          DEB_P: begin
            if (!btn_raw[i]) begin
              r_st[i]  <= REL;
              r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
              r_st[i]  <= PRS;
              r_cnt[i] <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + CNT_ONE;
            end
          end
          PRS: begin
            if (!btn_raw[i]) begin
              r_st[i]  <= DEB_R;
              r_cnt[i] <= CNT_ONE;
            end
          end
          default: begin
            if (btn_raw[i]) begin
              r_st[i]  <= PRS;
              r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
              r_st[i]  <= REL;
              r_cnt[i] <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + CNT_ONE;
            end
          end
        endcase
      end
    end
  end

  // Door-open clear outranks a same-edge press; fire recall wipes and blocks everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_latch <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= door_open && (bcd_floor > 4'd3);
      if (firealarm) r_latch <= '0;
      else           r_latch <= (r_latch | w_press) & ~w_clr;
    end
  end

  always_comb begin
    if (firealarm)     w_req = 4'b0001;
    else if (overload) w_req = '0;
    else               w_req = r_latch;
  end

  assign reqG      = w_req[0];
  assign reqF1     = w_req[1];
  assign reqF2     = w_req[2];
  assign reqF3     = w_req[3];
  assign lamp      = firealarm ? 4'b0000 : r_latch;
  assign busy      = |r_latch;
  assign err_floor = r_err;

endmodule
